fp_mul_arbiter: RTL and testbench
=================================

Name: fp_mul_arbiter

Overview:
- Shares one floating_point_multiplier instance between NUM_REQ requesters.
- Round-robin arbitration; latches the granted requester's operands; sequences the multiplier with a start/done handshake.
- Returns the 32-bit result to the winner with a one-cycle ack.
- A watchdog recovers from a multiplier that never reports done.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester index, equals ceil(log2(NUM_REQ))
TIMEOUT, 64, max cycles in WAIT before abort (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester request level
op_a  input  32*NUM_REQ  requester i operand A at [32*i+31:32*i]
op_b  input  32*NUM_REQ  requester i operand B, same packing
ack  output  NUM_REQ  one-hot one-cycle pulse, result valid for that requester
rsp_result  output  32  result, valid while rsp_valid=1
rsp_valid  output  1  one-cycle pulse, coincident with ack
rsp_id  output  ID_W  index of the requester being answered
timeout_err  output  1  one-cycle pulse with rsp_valid on watchdog abort
busy  output  1  high in any state except IDLE
mul_start  output  1  one-cycle start pulse to multiplier
mul_a  output  32  latched operand A to multiplier
mul_b  output  32  latched operand B to multiplier
mul_result  input  32  multiplier result
mul_done  input  1  multiplier completion pulse
mul_flush  output  1  one-cycle pulse requesting multiplier reset after abort

Behaviour:
- All outputs are registered. Reset values:
  - ack=0, rsp_valid=0, timeout_err=0, mul_start=0, mul_flush=0, busy=0.
  - rsp_result=0, rsp_id=0, mul_a=0, mul_b=0.
  - state=IDLE, rr pointer=0, watchdog=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is set, grant the first set bit at or after the rr pointer, searching upward with wrap.
  - Latch that requester's op_a/op_b into mul_a/mul_b and its index into gnt_id.
  - Next state ISSUE.
  - If no req, stay in IDLE.
- ISSUE:
  - mul_start=1 for exactly this cycle.
  - Clear watchdog; next state WAIT.
- WAIT:
  - mul_done=1: capture mul_result into rsp_result; next state RESP.
  - Otherwise increment watchdog.
  - When watchdog reaches TIMEOUT-1 with no done: rsp_result=32'h7FC00000 (quiet NaN); set abort flag; next state RESP.
  - If mul_done and the timeout coincide in the same cycle, done wins (normal result, no error).
- RESP:
  - ack[gnt_id]=1, rsp_valid=1, rsp_id=gnt_id for one cycle.
  - If aborted, also timeout_err=1 and mul_flush=1.
  - rr pointer <= gnt_id+1 (wraps to 0 after NUM_REQ-1).
  - Next state IDLE.
- Latency:
  - req sampled in IDLE at cycle 0; mul_start at cycle 1; WAIT from cycle 2.
  - mul_done at cycle t gives ack/rsp_valid at t+1 and IDLE at t+2.
  - With a multiplier that raises done 1 cycle after start, ack appears at cycle 3.
- Requester rules:
  - Hold req and operands stable until ack.
  - Drop req on the cycle after ack unless a new operation is wanted.
  - Dropping req before grant is legal and means no grant.
  - Operands are sampled only at grant; later changes are ignored.
- mul_done outside WAIT is ignored, including stale done after abort or after reset.
- Only one operation is outstanding at a time; there is no queuing.
- Reset mid-operation:
  - Next cycle everything is at reset values and no ack is issued for the in-flight request.
  - A subsequent mul_done is ignored.
- Fairness: a requester holding req continuously is granted within NUM_REQ operations.
- busy=1 from ISSUE through RESP inclusive.

Test Plan:
- Single request: req=4'b0001, op_a=32'h40000000 (2.0), op_b=32'h40400000 (3.0); multiplier model returns 32'h40C00000 with done 3 cycles after start. Required: mul_start pulses once; ack=0001, rsp_valid=1, rsp_result=40C00000, rsp_id=0 one cycle after done.
- Round-robin: req=4'b1111 held, 8 operations. Required grant order 0,1,2,3,0,1,2,3; each ack one-hot; no requester is skipped.
- Pointer wrap/skip: after serving id 2, set req=4'b0011. Required next grant 0, then 1.
- Timeout: multiplier never raises done, TIMEOUT=64. Required: exactly 64 WAIT cycles, then rsp_result=7FC00000 with timeout_err=1 and mul_flush=1 together with ack. A late mul_done in IDLE produces no response.
- Coincident done and timeout: done arrives on the final watchdog cycle. Required: normal result, timeout_err=0.
- Reset mid-WAIT: assert reset 2 cycles after mul_start. Required: all outputs zero the next cycle; no ack; done pulse afterwards ignored; a new request then completes normally.

Source files
------------

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter that time-shares one floating-point multiplier between
// NUM_REQ requesters, with a start/done handshake and a WAIT-state watchdog.
module fp_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [32*NUM_REQ-1:0] op_a,
  input  logic [32*NUM_REQ-1:0] op_b,
  output logic [NUM_REQ-1:0]    ack,
  output logic [31:0]           rsp_result,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  timeout_err,
  output logic                  busy,
  output logic                  mul_start,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  input  logic [31:0]           mul_result,
  input  logic                  mul_done,
  output logic                  mul_flush
);
  localparam int          WD_W = $clog2(TIMEOUT);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      rr_q, rr_d, gnt_q, gnt_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic                 abort_q, abort_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [31:0]          rsp_result_q, rsp_result_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic                 tmo_q, tmo_d;
  logic                 busy_q, busy_d;
  logic                 start_q, start_d;
  logic [31:0]          mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic                 flush_q, flush_d;

  logic                 found;
  logic [ID_W-1:0]      sel;
  int                   idx;

  // First requester at or after the rr pointer, searching upward with wrap.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    gnt_d        = gnt_q;
    wd_d         = wd_q;
    abort_d      = abort_q;
    ack_d        = '0;
    rsp_result_d = rsp_result_q;
    rsp_valid_d  = 1'b0;
    rsp_id_d     = rsp_id_q;
    tmo_d        = 1'b0;
    start_d      = 1'b0;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    flush_d      = 1'b0;
    unique case (state_q)
      IDLE: if (found) begin
        gnt_d   = sel;
        mul_a_d = op_a[32*int'(sel) +: 32];
        mul_b_d = op_b[32*int'(sel) +: 32];
        abort_d = 1'b0;
        start_d = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // done takes priority over a watchdog expiring in the same cycle
        if (mul_done) begin
          rsp_result_d = mul_result;
          state_d      = RESP;
        end else if (wd_q == WD_W'(TIMEOUT-1)) begin
          rsp_result_d = QNAN;
          abort_d      = 1'b1;
          state_d      = RESP;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
        // Response outputs are registered on entry so they coincide with RESP.
        if (state_d == RESP) begin
          ack_d[gnt_q] = 1'b1;
          rsp_valid_d  = 1'b1;
          rsp_id_d     = gnt_q;
          tmo_d        = abort_d;
          flush_d      = abort_d;
        end
      end
      RESP: begin
        rr_d    = (int'(gnt_q) == NUM_REQ-1) ? '0 : gnt_q + ID_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      gnt_q        <= '0;
      wd_q         <= '0;
      abort_q      <= 1'b0;
      ack_q        <= '0;
      rsp_result_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      tmo_q        <= 1'b0;
      busy_q       <= 1'b0;
      start_q      <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      flush_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      gnt_q        <= gnt_d;
      wd_q         <= wd_d;
      abort_q      <= abort_d;
      ack_q        <= ack_d;
      rsp_result_q <= rsp_result_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      tmo_q        <= tmo_d;
      busy_q       <= busy_d;
      start_q      <= start_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      flush_q      <= flush_d;
    end
  end

  assign ack         = ack_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign timeout_err = tmo_q;
  assign busy        = busy_q;
  assign mul_start   = start_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign mul_flush   = flush_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Randomized bench for fp_mul_arbiter: a delay-programmable multiplier model
// plus a round-robin reference that predicts grant, result and latency.
module tb_fp_mul_arbiter;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int TO = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req;
  logic [32*NR-1:0]  op_a, op_b;
  logic [NR-1:0]     ack;
  logic [31:0]       rsp_result;
  logic              rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic              timeout_err, busy, mul_start, mul_flush, mul_done;
  logic [31:0]       mul_a, mul_b, mul_result;
  logic              mdl_done, man_done;

  int                cmp_cnt = 0;
  int                err_cnt = 0;
  int                mul_dly;
  int                ptr;
  int                gid;
  logic [31:0]       oa[NR], ob[NR];

  fp_mul_arbiter #(.NUM_REQ(NR), .ID_W(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b),
    .ack(ack), .rsp_result(rsp_result), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .timeout_err(timeout_err), .busy(busy), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result), .mul_done(mul_done),
    .mul_flush(mul_flush)
  );

  always #5 clk = ~clk;
  assign mul_done = mdl_done | man_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    return (a ^ {b[15:0], b[31:16]}) + 32'd1;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < NR; i++) begin
      op_a[32*i +: 32] = oa[i];
      op_b[32*i +: 32] = ob[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NR; i++) begin
      oa[i] = $urandom;
      ob[i] = $urandom;
    end
  endtask

  // Multiplier model: done pulses `mul_dly` cycles after the start cycle.
  initial begin
    logic [31:0] ra, rb;
    int          d;
    mdl_done   = 1'b0;
    mul_result = '0;
    forever begin
      @(negedge clk);
      if (mul_start && mul_dly >= 0) begin
        ra = mul_a;
        rb = mul_b;
        d  = mul_dly;
        repeat (d) @(posedge clk);
        #1 mdl_done = 1'b1;
        mul_result = fmul(ra, rb);
        @(posedge clk);
        #1 mdl_done = 1'b0;
      end
    end
  end

  // Called at #1 after a posedge with the DUT in IDLE; returns granted id.
  task automatic run_op(input logic [NR-1:0] rq, input int dly, output int id);
    int          lat, starts, cyc;
    logic        tmo, got;
    logic [31:0] exp_res;
    id = -1;
    for (int k = 0; k < NR; k++)
      if (id < 0 && rq[(ptr + k) % NR]) id = (ptr + k) % NR;
    mul_dly = dly;
    req     = rq;
    drive_ops();
    tmo     = (dly < 0) || (dly > TO);
    lat     = tmo ? TO + 2 : dly + 2;
    exp_res = tmo ? 32'h7FC0_0000 : fmul(oa[id], ob[id]);
    starts  = 0;
    got     = 1'b0;
    cyc     = 0;
    while (!got && cyc < TO + 20) begin
      @(posedge clk); #1;
      cyc++;
      if (mul_start) starts++;
      if (cyc == 1) begin
        chk("busy_issue", 32'(busy), 32'd1);
        rand_ops();
        drive_ops();
      end
      got = rsp_valid;
    end
    chk("ack_seen", 32'(got), 32'd1);
    chk("latency", 32'(cyc), 32'(lat));
    chk("ack_onehot", 32'(ack), 32'(1) << id);
    chk("rsp_id", 32'(rsp_id), 32'(id));
    chk("rsp_result", rsp_result, exp_res);
    chk("timeout_err", 32'(timeout_err), 32'(tmo));
    chk("mul_flush", 32'(mul_flush), 32'(tmo));
    chk("start_count", 32'(starts), 32'd1);
    req = '0;
    ptr = (id + 1) % NR;
    @(posedge clk); #1;
    chk("ack_clear", 32'({rsp_valid, ack, timeout_err, mul_flush, busy}), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    ptr   = 0;
  endtask

  initial begin
    logic bad;
    reset = 1'b1; req = '0; op_a = '0; op_b = '0; man_done = 1'b0; mul_dly = 1; ptr = 0;
    for (int i = 0; i < NR; i++) begin oa[i] = '0; ob[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", 32'({ack, rsp_valid, timeout_err, mul_start, mul_flush, busy}), 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_mul_a", mul_a, 32'd0);
    chk("rst_mul_b", mul_b, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 2.0 * 3.0 with done three cycles after start
    oa[0] = 32'h4000_0000; ob[0] = 32'h4040_0000;
    run_op(4'b0001, 3, gid);
    chk("single_result", rsp_result, 32'h40C0_0000);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      run_op(4'b1111, int'($urandom_range(1, 4)), gid);
      chk("rr_order", 32'(gid), 32'(i % 4));
    end

    run_op(4'b0100, 2, gid);
    chk("skip_id2", 32'(gid), 32'd2);
    run_op(4'b0011, 1, gid);
    chk("wrap_id0", 32'(gid), 32'd0);
    run_op(4'b0011, 1, gid);
    chk("wrap_id1", 32'(gid), 32'd1);

    for (int i = 0; i < 12; i++) begin
      rand_ops();
      run_op(NR'($urandom_range(1, 15)), int'($urandom_range(1, 6)), gid);
    end

    // Watchdog abort, then a stale done while idle
    rand_ops();
    run_op(4'b0010, -1, gid);
    man_done = 1'b1;
    @(posedge clk); #1;
    man_done = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      bad = bad | rsp_valid | busy | mul_start;
    end
    chk("late_done_ignored", 32'(bad), 32'd0);

    // Done on the final watchdog cycle, and one cycle earlier
    rand_ops();
    run_op(4'b1000, TO, gid);
    rand_ops();
    run_op(4'b0100, TO - 1, gid);

    // Reset two cycles after mul_start
    rand_ops();
    mul_dly = 5;
    req = 4'b0001;
    drive_ops();
    @(posedge clk); #1;
    chk("rst_mid_start", 32'(mul_start), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    req   = '0;
    @(posedge clk); #1;
    chk("rst_mid_ctl", 32'({ack, rsp_valid, timeout_err, mul_start, mul_flush, busy}), 32'd0);
    chk("rst_mid_result", rsp_result, 32'd0);
    chk("rst_mid_id", 32'(rsp_id), 32'd0);
    chk("rst_mid_mul_a", mul_a, 32'd0);
    chk("rst_mid_mul_b", mul_b, 32'd0);
    reset = 1'b0;
    ptr   = 0;
    bad   = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      bad = bad | rsp_valid | busy;
    end
    chk("rst_stale_done", 32'(bad), 32'd0);
    chk("rst_stale_result", rsp_result, 32'd0);
    rand_ops();
    run_op(4'b0110, 2, gid);
    chk("post_rst_id", 32'(gid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

endmodule
